// File: rtl/issue_buffer.sv
// issue_buffer: dual-push / dual-pop instruction buffer between IF and ID.
// Define IB_STAT_EN to add full / branch-hold / dual-pop cycle counters.
module issue_buffer #(
  parameter int DEPTH  = 16,
  parameter int PC_W   = 32,
  parameter int INST_W = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic                    stall,
  input  logic [1:0]              in_valid,
  input  logic [PC_W-1:0]         in_pc0,
  input  logic [INST_W-1:0]       in_inst0,
  input  logic [PC_W-1:0]         in_pc1,
  input  logic [INST_W-1:0]       in_inst1,
  output logic                    in_ready,
  input  logic [1:0]              pop_num,
  output logic                    out0_valid,
  output logic [PC_W-1:0]         out0_pc,
  output logic [INST_W-1:0]       out0_inst,
  output logic                    out1_valid,
  output logic [PC_W-1:0]         out1_pc,
  output logic [INST_W-1:0]       out1_inst,
  output logic [$clog2(DEPTH):0]  count
`ifdef IB_STAT_EN
  ,
  output logic [31:0]             stat_full_cyc,
  output logic [31:0]             stat_hold_cyc,
  output logic [31:0]             stat_dual_pop
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [PC_W-1:0]   pc_mem   [DEPTH];
  logic [INST_W-1:0] inst_mem [DEPTH];

  logic [AW-1:0]     head, tail, head1, tail1;
  logic [CW-1:0]     cnt;
  logic [PC_W-1:0]   head_pc, next_pc;
  logic [INST_W-1:0] head_inst, next_inst;
  logic [5:0]        op, fn;
  logic              ctrl, br_hold, v0, v1;
  logic [1:0]        push_n, pop_sat, vis, eff_pop;

  assign head1     = head + 1'b1;
  assign tail1     = tail + 1'b1;
  assign head_pc   = pc_mem[head];
  assign head_inst = inst_mem[head];
  assign next_pc   = pc_mem[head1];
  assign next_inst = inst_mem[head1];
  assign op        = head_inst[31:26];
  assign fn        = head_inst[5:0];

  // Predecode the head: jumps, branches, REGIMM, JR/JALR.
  always_comb begin
    ctrl = 1'b0;
    case (op)
      6'b000001, 6'b000010, 6'b000011,
      6'b000100, 6'b000101, 6'b000110,
      6'b000111: ctrl = 1'b1;
      6'b000000: ctrl = (fn == 6'b001000) || (fn == 6'b001001);
      default:   ctrl = 1'b0;
    endcase
  end

  // A lone control transfer waits until its delay slot arrives.
  assign br_hold  = (cnt == CW'(1)) & ctrl;
  assign v0       = (cnt != '0) & ~br_hold;
  assign v1       = (cnt > CW'(1)) & v0;
  assign in_ready = (cnt <= CW'(DEPTH - 2));

  // Number of entries accepted this cycle; 2'b10 is ignored.
  always_comb begin
    push_n = 2'd0;
    if (in_ready) begin
      case (in_valid)
        2'b01:   push_n = 2'd1;
        2'b11:   push_n = 2'd2;
        default: push_n = 2'd0;
      endcase
    end
  end

  assign pop_sat = (pop_num == 2'd3) ? 2'd2 : pop_num;
  assign vis     = {1'b0, v0} + {1'b0, v1};
  assign eff_pop = stall ? 2'd0 : ((pop_sat < vis) ? pop_sat : vis);

  assign out0_valid = v0;
  assign out1_valid = v1;
  assign out0_pc    = v0 ? head_pc   : '0;
  assign out0_inst  = v0 ? head_inst : '0;
  assign out1_pc    = v1 ? next_pc   : '0;
  assign out1_inst  = v1 ? next_inst : '0;
  assign count      = cnt;

  // Storage write at tail (and tail+1 for a pair).
  always_ff @(posedge clk) begin
    if (rst && !flush && push_n != 2'd0) begin
      pc_mem[tail]   <= in_pc0;
      inst_mem[tail] <= in_inst0;
      if (push_n == 2'd2) begin
        pc_mem[tail1]   <= in_pc1;
        inst_mem[tail1] <= in_inst1;
      end
    end
  end

  // Pointers and occupancy; reset and flush drop everything at once.
  always_ff @(posedge clk) begin
    if (!rst || flush) begin
      head <= '0;
      tail <= '0;
      cnt  <= '0;
    end else begin
      head <= head + AW'(eff_pop);
      tail <= tail + AW'(push_n);
      cnt  <= cnt + CW'(push_n) - CW'(eff_pop);
    end
  end

`ifdef IB_STAT_EN
  // Free-running event counters, cleared only by reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      stat_full_cyc <= '0;
      stat_hold_cyc <= '0;
      stat_dual_pop <= '0;
    end else begin
      if (!in_ready)         stat_full_cyc <= stat_full_cyc + 32'd1;
      if (br_hold)           stat_hold_cyc <= stat_hold_cyc + 32'd1;
      if (eff_pop == 2'd2)   stat_dual_pop <= stat_dual_pop + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_issue_buffer.sv
// tb_issue_buffer: directed plus random stimulus for issue_buffer,
// checked against a queue model of the buffer.
module tb_issue_buffer;

  localparam int DEPTH = 16;
  localparam logic [31:0] ADDU = 32'h00221021;
  localparam logic [31:0] BEQ  = 32'h10220003;

  logic        clk = 1'b0;
  logic        rst, flush, stall;
  logic [1:0]  in_valid, pop_num;
  logic [31:0] in_pc0, in_inst0, in_pc1, in_inst1;
  logic        in_ready, out0_valid, out1_valid;
  logic [31:0] out0_pc, out0_inst, out1_pc, out1_inst;
  logic [4:0]  count;
`ifdef IB_STAT_EN
  logic [31:0] stat_full_cyc, stat_hold_cyc, stat_dual_pop;
`endif

  always #5 clk = ~clk;

  issue_buffer #(.DEPTH(DEPTH), .PC_W(32), .INST_W(32)) dut (
    .clk(clk), .rst(rst), .flush(flush), .stall(stall),
    .in_valid(in_valid),
    .in_pc0(in_pc0), .in_inst0(in_inst0),
    .in_pc1(in_pc1), .in_inst1(in_inst1),
    .in_ready(in_ready), .pop_num(pop_num),
    .out0_valid(out0_valid), .out0_pc(out0_pc), .out0_inst(out0_inst),
    .out1_valid(out1_valid), .out1_pc(out1_pc), .out1_inst(out1_inst),
    .count(count)
`ifdef IB_STAT_EN
    , .stat_full_cyc(stat_full_cyc)
    , .stat_hold_cyc(stat_hold_cyc)
    , .stat_dual_pop(stat_dual_pop)
`endif
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } ent_t;

  ent_t        q[$];
  int          tests = 0;
  int          fails = 0;
  logic [31:0] pc = 32'hBFC00000;

  function automatic bit is_cti(logic [31:0] i);
    logic [5:0] o = i[31:26];
    logic [5:0] f = i[5:0];
    return (o >= 6'd1 && o <= 6'd7) ||
           (o == 6'd0 && (f == 6'h08 || f == 6'h09));
  endfunction

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(string tag);
    int n = q.size();
    bit hold = (n == 1) && is_cti(q[0].inst);
    bit e0 = (n >= 1) && !hold;
    bit e1 = e0 && (n >= 2);
    chk({tag, ".count"}, 64'(count), 64'(n));
    chk({tag, ".ready"}, 64'(in_ready), 64'(n <= DEPTH - 2));
    chk({tag, ".v0"}, 64'(out0_valid), 64'(e0));
    chk({tag, ".v1"}, 64'(out1_valid), 64'(e1));
    chk({tag, ".pc0"}, 64'(out0_pc), e0 ? 64'(q[0].pc) : 64'd0);
    chk({tag, ".inst0"}, 64'(out0_inst), e0 ? 64'(q[0].inst) : 64'd0);
    chk({tag, ".pc1"}, 64'(out1_pc), e1 ? 64'(q[1].pc) : 64'd0);
    chk({tag, ".inst1"}, 64'(out1_inst), e1 ? 64'(q[1].inst) : 64'd0);
  endtask

  // One clock: check current outputs, apply inputs, advance model.
  task automatic step(string tag, bit f, bit s, logic [1:0] iv,
                      logic [31:0] p0, logic [31:0] i0,
                      logic [31:0] p1, logic [31:0] i1,
                      logic [1:0] pn);
    int n, vis, want;
    bit hold, rdy;
    flush = f; stall = s; in_valid = iv; pop_num = pn;
    in_pc0 = p0; in_inst0 = i0; in_pc1 = p1; in_inst1 = i1;
    check_all(tag);
    n = q.size();
    hold = (n == 1) && is_cti(q[0].inst);
    vis = (n >= 1 && !hold) ? ((n >= 2) ? 2 : 1) : 0;
    rdy = (n <= DEPTH - 2);
    want = (pn == 2'd3) ? 2 : int'(pn);
    @(posedge clk);
    if (f) begin
      q.delete();
    end else begin
      if (!s)
        for (int k = 0; k < ((want < vis) ? want : vis); k++)
          void'(q.pop_front());
      if (rdy && iv[0]) q.push_back('{p0, i0});
      if (rdy && iv == 2'b11) q.push_back('{p1, i1});
    end
    @(negedge clk);
  endtask

  task automatic push2(string tag, logic [1:0] pn);
    step(tag, 0, 0, 2'b11, pc, ADDU, pc + 4, ADDU, pn);
    pc += 8;
  endtask

  task automatic idle(string tag);
    step(tag, 0, 0, 2'b00, 0, 0, 0, 0, 2'd0);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    step("rst", 0, 0, 2'b11, pc, ADDU, pc + 4, ADDU, 2'd0);
    q.delete();
    rst = 1'b1;
  endtask

  initial begin
    rst = 1'b0; flush = 0; stall = 0; in_valid = 0; pop_num = 0;
    in_pc0 = 0; in_inst0 = 0; in_pc1 = 0; in_inst1 = 0;
    @(posedge clk);
    @(negedge clk);
    q.delete();
    rst = 1'b1;
    check_all("reset");
    chk("reset.ready", 64'(in_ready), 64'd1);

    // First pair becomes visible the following cycle.
    push2("tp1", 2'd0);
    check_all("tp1.after");
    chk("tp1.count", 64'(count), 64'd2);
    chk("tp1.pc0", 64'(out0_pc), 64'hBFC00000);
    chk("tp1.pc1", 64'(out1_pc), 64'hBFC00004);

    // Fill to DEPTH, push while full is dropped.
    for (int k = 0; k < 7; k++) push2("fill", 2'd0);
    chk("fill.count", 64'(count), 64'd16);
    chk("fill.ready", 64'(in_ready), 64'd0);
    push2("fill.drop", 2'd0);
    chk("fill.drop.count", 64'(count), 64'd16);
    step("pop1", 0, 0, 2'b00, 0, 0, 0, 0, 2'd1);
    chk("full15.count", 64'(count), 64'd15);
    chk("full15.ready", 64'(in_ready), 64'd0);
    step("pop1b", 0, 0, 2'b00, 0, 0, 0, 0, 2'd1);
    chk("c14.ready", 64'(in_ready), 64'd1);

    // Steady push 2 / pop 2 at count 14 across three wraps.
    for (int k = 0; k < 3 * DEPTH / 2; k++) push2("wrap", 2'd2);
    chk("wrap.count", 64'(count), 64'd14);

    // Branch waits for its delay slot.
    do_reset();
    step("beq", 0, 0, 2'b01, pc, BEQ, 0, 0, 2'd0);
    chk("beq.v0", 64'(out0_valid), 64'd0);
    step("slot", 0, 0, 2'b01, pc + 4, ADDU, 0, 0, 2'd0);
    pc += 8;
    chk("slot.v0", 64'(out0_valid), 64'd1);
    chk("slot.v1", 64'(out1_valid), 64'd1);

    // Flush at count 9 with a same-cycle push.
    do_reset();
    for (int k = 0; k < 4; k++) push2("f9", 2'd0);
    step("f9b", 0, 0, 2'b01, pc, ADDU, 0, 0, 2'd0);
    pc += 4;
    chk("f9.count", 64'(count), 64'd9);
    step("flush", 1, 0, 2'b11, pc, ADDU, pc + 4, ADDU, 2'd0);
    chk("flush.count", 64'(count), 64'd0);
    chk("flush.pc0", 64'(out0_pc), 64'd0);
    check_all("flush.after");

    // Stall blocks the pop.
    push2("st", 2'd0);
    push2("st", 2'd0);
    step("stall", 0, 1, 2'b00, 0, 0, 0, 0, 2'd2);
    chk("stall.count", 64'(count), 64'd4);

    // pop_num=3 with a single visible entry.
    do_reset();
    step("one", 0, 0, 2'b01, pc, ADDU, 0, 0, 2'd0);
    pc += 4;
    step("pop3", 0, 0, 2'b00, 0, 0, 0, 0, 2'd3);
    chk("pop3.count", 64'(count), 64'd0);

    // Random traffic.
    for (int k = 0; k < 3000; k++) begin
      logic [31:0] i0, i1;
      logic [1:0] iv;
      i0 = ($urandom_range(0, 3) == 0) ?
           {6'($urandom_range(1, 7)), 26'($urandom)} :
           {6'($urandom_range(8, 63)), 26'($urandom)};
      i1 = ($urandom_range(0, 7) == 0) ? 32'h03e00008 : 32'($urandom);
      iv = 2'($urandom);
      step("rnd", ($urandom_range(0, 99) == 0), ($urandom_range(0, 5) == 0),
           iv, pc, i0, pc + 4, i1, 2'($urandom));
      pc += 8;
    end

    // Mid-run reset.
    for (int k = 0; k < 3; k++) push2("mr", 2'd0);
    do_reset();
    chk("mr.count", 64'(count), 64'd0);
    chk("mr.v0", 64'(out0_valid), 64'd0);
    check_all("final");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
